uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-stream frame parser directly downstream of the UART receiver. It consumes the receiver's one-cycle `rcv` strobe and 8-bit data byte, and assembles framed commands of the form header, length, payload, XOR checksum. It presents a validated payload with a one-cycle valid pulse and flags checksum, length and inter-byte timeout errors. It sits between the UART receive path and the command/register logic.

## Interface
- `HEADER`, default 8'hFE: start-of-frame byte.
- `MAX_LEN`, default 8: maximum payload bytes (1..15).
- `TIMEOUT`, default 21700: max clk cycles allowed between consecutive bytes inside a frame (about 2 byte times at 115200 baud, 125 MHz).

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `i_rcv`  in  1  byte-received strobe from the UART receiver, one cycle wide.
- `i_data`  in  8  received byte; sampled only when `i_rcv`=1.
- `o_valid`  out  1  one-cycle pulse: good frame available on `o_len`/`o_payload`.
- `o_len`  out  4  payload length of the last good frame.
- `o_payload`  out  8*MAX_LEN  payload of the last good frame; byte k at bits [8k+7:8k].
- `o_err_chk`  out  1  one-cycle pulse: checksum mismatch.
- `o_err_len`  out  1  one-cycle pulse: length byte 0 or > MAX_LEN.
- `o_err_tmo`  out  1  one-cycle pulse: inter-byte timeout inside a frame.
- `o_busy`  out  1  high while parsing a frame (state ≠ IDLE).

## Operation
- The state machine has four states: IDLE, LEN, DATA, CHK.
- IDLE: bytes ≠ `HEADER` are ignored with no error. `HEADER` moves to LEN.
- LEN:
  - On a byte L with 1 ≤ L ≤ MAX_LEN: store L, clear the byte index and set the running checksum to L, then go to DATA.
  - Otherwise pulse `o_err_len` and go to IDLE.
- DATA: each byte is written to internal buffer slot [index] and XORed into the checksum, then the index increments. When the index reaches L-1 on a received byte, go to CHK. A `HEADER` value here is plain data.
- CHK:
  - If the byte equals the running checksum, copy the buffer to `o_payload` and L to `o_len`, and pulse `o_valid`.
  - Otherwise pulse `o_err_chk`.
  - Both outcomes go to IDLE.
- `o_payload`/`o_len` change only on a good frame. Buffer slots ≥ L are zero in `o_payload`; the buffer is cleared at LEN.
- Timeout counter:
  - Cleared on every `i_rcv` and while in IDLE. Increments each cycle in LEN/DATA/CHK.
  - On reaching TIMEOUT-1: pulse `o_err_tmo`, go to IDLE, discard the partial frame.
- The error and valid pulses are mutually exclusive. At most one is asserted per cycle.

## Timing
- Reset values: state IDLE, `o_valid`=0, `o_err_*`=0, `o_busy`=0, `o_len`=0, `o_payload`=0, counter 0.
- All outputs are registered.
- `o_valid`/`o_err_chk`/`o_err_len` assert exactly one cycle after the `i_rcv` cycle of the deciding byte.
- `o_err_tmo` asserts one cycle after the counter reaches TIMEOUT-1.
- `o_busy` rises the cycle after the header strobe and falls in the same cycle as the terminating pulse.
- Simultaneous `i_rcv` and timeout terminal count: the byte wins. The counter clears and no timeout is flagged.
- `rst` mid-frame: returns to IDLE next cycle and clears outputs; no pulse is emitted.
- Back-to-back frames are legal. A header may arrive the cycle after the terminating pulse.

## Structure
- Package `pkg_uart` holds:
  - the state enum `e_frame_state`;
  - constant `FRAME_HEADER`;
  - struct `st_frame_parser` bundling internal wires (index, checksum, count, terminal count, buffer write enable).
- Sub-module `frame_timer`: a clearable up-counter with terminal-count output, parameterised by TIMEOUT, with synchronous active-high `rst`.
- The FSM, buffer and output registers stay in the top module.

## Test plan
- Good frame: FE 03 11 22 33 03 → `o_valid` pulse, `o_len`=3, `o_payload`[23:0]=24'h332211, upper bytes 0.
- Bad checksum: FE 02 AA 55 00 (expected FD) → `o_err_chk` pulse; `o_payload`/`o_len` keep their previous values.
- Length errors: FE 00, then FE 09 (MAX_LEN=8) → `o_err_len` pulse after each length byte; next FE 01 5A 5B → `o_valid`, `o_len`=1, byte0=5A.
- Timeout: FE 02 AA then silence → `o_err_tmo` exactly TIMEOUT cycles after the AA strobe; `o_busy` low afterwards. A byte strobe on the terminal-count cycle → no error.
- Garbage and embedded header: 00 7F FE 02 FE 01 FD → garbage ignored, `o_valid` with payload bytes FE, 01.
- Reset mid-frame: FE 03 11 then `rst` for 1 cycle, then a full good frame → no pulse from the aborted frame; the good frame is reported correctly.

Source files
------------

// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser.
//   e_frame_state   : parser FSM states
//   FRAME_HEADER    : default start-of-frame byte
//   st_frame_parser : bundle of internal parser wires (also exported as the
//                     debug view of the FSM)
package pkg_uart;

  localparam logic [7:0] FRAME_HEADER = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } e_frame_state;

  typedef struct packed {
    e_frame_state state;   // current FSM state
    logic [3:0]   idx;     // payload byte index
    logic [7:0]   chk;     // running XOR checksum
    logic [31:0]  count;   // inter-byte timer value, zero-extended
    logic         tc;      // timer terminal count
    logic         buf_we;  // payload buffer write enable
  } st_frame_parser;

endpackage

// File: rtl/uart_frame_parser_timer.sv
// frame_timer: clearable up-counter with terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   count    : current value
//   tc       : high while count == TIMEOUT-1; the counter holds there
// TIMEOUT must be at least 2.
module frame_timer #(
  parameter int TIMEOUT = 21700
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  output logic [$clog2(TIMEOUT)-1:0] count,
  output logic                       tc
);

  localparam int CW = $clog2(TIMEOUT);

  assign tc = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles frames HEADER, LEN, payload[LEN], XOR checksum
// from the UART receiver byte strobe and reports good frames and errors.
//   clk, rst    : clock, synchronous active-high reset
//   i_rcv       : one-cycle byte strobe; i_data sampled only when high
//   i_data      : received byte
//   o_valid     : one-cycle pulse, good frame on o_len / o_payload
//   o_len       : payload length of last good frame
//   o_payload   : payload of last good frame, byte k at [8k+7:8k]
//   o_err_chk   : one-cycle pulse, checksum mismatch
//   o_err_len   : one-cycle pulse, length byte 0 or > MAX_LEN
//   o_err_tmo   : one-cycle pulse, inter-byte timeout inside a frame
//   o_busy      : high while a frame is being parsed
//   o_dbg       : FSM state and internal parser wires
// Handshake: i_rcv is a strobe with no back-pressure; every strobe is
// consumed in the cycle it is presented. Outputs are all registered and the
// four pulses are mutually exclusive.
module uart_frame_parser
  import pkg_uart::*;
#(
  parameter logic [7:0] HEADER  = FRAME_HEADER,
  parameter int         MAX_LEN = 8,
  parameter int         TIMEOUT = 21700
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rcv,
  input  logic [7:0]             i_data,
  output logic                   o_valid,
  output logic [3:0]             o_len,
  output logic [8*MAX_LEN-1:0]   o_payload,
  output logic                   o_err_chk,
  output logic                   o_err_len,
  output logic                   o_err_tmo,
  output logic                   o_busy,
  output st_frame_parser         o_dbg
);

  localparam int CW = $clog2(TIMEOUT);

  e_frame_state             state_q, state_n;
  logic [3:0]               idx_q, idx_n;
  logic [7:0]               chk_q, chk_n;
  logic [3:0]               len_q, len_n;
  logic [MAX_LEN-1:0][7:0]  buf_q;

  logic buf_clr, buf_we, commit;
  logic valid_n, err_chk_n, err_len_n, err_tmo_n;

  logic [CW-1:0] tmr_count;
  logic          tmr_tc;

  // Counter idles at zero outside a frame and restarts on every byte.
  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_rcv || (state_q == ST_IDLE)),
    .en    (state_q != ST_IDLE),
    .count (tmr_count),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    chk_n     = chk_q;
    len_n     = len_q;
    buf_clr   = 1'b0;
    buf_we    = 1'b0;
    commit    = 1'b0;
    valid_n   = 1'b0;
    err_chk_n = 1'b0;
    err_len_n = 1'b0;
    err_tmo_n = 1'b0;

    // A byte arriving on the terminal-count cycle takes priority.
    if (state_q != ST_IDLE && !i_rcv && tmr_tc) begin
      err_tmo_n = 1'b1;
      state_n   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rcv && i_data == HEADER) begin
            state_n = ST_LEN;
          end
        end
        ST_LEN: begin
          if (i_rcv) begin
            buf_clr = 1'b1;
            if (i_data != 8'd0 && i_data <= 8'(MAX_LEN)) begin
              len_n   = i_data[3:0];
              idx_n   = 4'd0;
              chk_n   = i_data;
              state_n = ST_DATA;
            end else begin
              err_len_n = 1'b1;
              state_n   = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (i_rcv) begin
            buf_we = 1'b1;
            chk_n  = chk_q ^ i_data;
            if (idx_q == len_q - 4'd1) begin
              state_n = ST_CHK;
            end else begin
              idx_n = idx_q + 4'd1;
            end
          end
        end
        ST_CHK: begin
          if (i_rcv) begin
            if (i_data == chk_q) begin
              valid_n = 1'b1;
              commit  = 1'b1;
            end else begin
              err_chk_n = 1'b1;
            end
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      chk_q     <= '0;
      len_q     <= '0;
      buf_q     <= '0;
      o_valid   <= 1'b0;
      o_err_chk <= 1'b0;
      o_err_len <= 1'b0;
      o_err_tmo <= 1'b0;
      o_busy    <= 1'b0;
      o_len     <= '0;
      o_payload <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      chk_q     <= chk_n;
      len_q     <= len_n;
      o_valid   <= valid_n;
      o_err_chk <= err_chk_n;
      o_err_len <= err_len_n;
      o_err_tmo <= err_tmo_n;
      o_busy    <= (state_n != ST_IDLE);

      // Clearing at the length byte keeps slots >= L zero in the payload.
      if (buf_clr) begin
        buf_q <= '0;
      end else if (buf_we) begin
        for (int k = 0; k < MAX_LEN; k++) begin
          if (idx_q == 4'(k)) begin
            buf_q[k] <= i_data;
          end
        end
      end

      if (commit) begin
        o_payload <= buf_q;
        o_len     <= len_q;
      end
    end
  end

  assign o_dbg = '{
    state:  state_q,
    idx:    idx_q,
    chk:    chk_q,
    count:  32'(tmr_count),
    tc:     tmr_tc,
    buf_we: buf_we
  };

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;
  import pkg_uart::*;

  localparam int         MAX_LEN = 8;
  localparam int         TIMEOUT = 40;
  localparam logic [7:0] HDR     = 8'hFE;
  localparam int         EW      = 5 + 4 + 8 * MAX_LEN;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_rcv = 1'b0;
  logic [7:0]           i_data = 8'h00;
  logic                 o_valid;
  logic [3:0]           o_len;
  logic [8*MAX_LEN-1:0] o_payload;
  logic                 o_err_chk;
  logic                 o_err_len;
  logic                 o_err_tmo;
  logic                 o_busy;
  st_frame_parser       o_dbg;

  uart_frame_parser #(.HEADER(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rcv     (i_rcv),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_len     (o_len),
    .o_payload (o_payload),
    .o_err_chk (o_err_chk),
    .o_err_len (o_err_len),
    .o_err_tmo (o_err_tmo),
    .o_busy    (o_busy),
    .o_dbg     (o_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0]        exp_q[$];
  logic [7:0]           stim_q[$];
  int                   gap_q[$];
  logic [3:0]           m_len = '0;
  logic [8*MAX_LEN-1:0] m_payload = '0;

  function automatic logic [EW-1:0] observed();
    return {o_valid, o_err_chk, o_err_len, o_err_tmo, o_busy, o_len, o_payload};
  endfunction

  // ---------------- reference model ----------------
  // Scans stim_q as a byte stream starting outside a frame and pushes, for
  // every byte, the expected output vector one cycle after its strobe.
  task automatic build_expect();
    int code_a[256];
    bit busy_a[256];
    int pstart_a[256];
    int plen_a[256];
    int n, i, len_b, last;
    logic [7:0] x;
    logic [3:0] code_bits;
    n = stim_q.size();
    for (int k = 0; k < n; k++) begin
      code_a[k] = 0; busy_a[k] = 1'b0; pstart_a[k] = 0; plen_a[k] = 0;
    end
    i = 0;
    while (i < n) begin
      if (stim_q[i] != HDR) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        busy_a[i] = 1'b1;
        break;
      end
      len_b = int'(stim_q[i+1]);
      if (len_b == 0 || len_b > MAX_LEN) begin
        busy_a[i] = 1'b1;
        code_a[i+1] = 3;
        i += 2;
        continue;
      end
      last = i + 2 + len_b;
      if (last >= n) begin
        for (int k = i; k < n; k++) busy_a[k] = 1'b1;
        break;
      end
      x = 8'(len_b);
      for (int k = 0; k < len_b; k++) x ^= stim_q[i+2+k];
      for (int k = i; k < last; k++) busy_a[k] = 1'b1;
      if (stim_q[last] == x) begin
        code_a[last]   = 1;
        pstart_a[last] = i + 2;
        plen_a[last]   = len_b;
      end else begin
        code_a[last] = 2;
      end
      i = last + 1;
    end
    for (int k = 0; k < n; k++) begin
      if (code_a[k] == 1) begin
        m_len     = 4'(plen_a[k]);
        m_payload = '0;
        for (int b = 0; b < plen_a[k]; b++) m_payload[8*b +: 8] = stim_q[pstart_a[k]+b];
      end
      code_bits = (code_a[k] == 1) ? 4'b1000 :
                  (code_a[k] == 2) ? 4'b0100 :
                  (code_a[k] == 3) ? 4'b0010 : 4'b0000;
      exp_q.push_back({code_bits, busy_a[k], m_len, m_payload});
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; the strobe is sampled at the next posedge and the
  // task returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    i_rcv  = 1'b1;
    i_data = b;
    @(negedge clk);
    i_rcv  = 1'b0;
    i_data = 8'($urandom_range(0, 255));
  endtask

  // Sends stim_q (gap_q[k] idle cycles after byte k, 0 if absent) and checks
  // the output vector after every strobe and on every idle cycle.
  task automatic run_stream(input string name);
    logic [EW-1:0] exp_v, idle_v;
    int g;
    build_expect();
    for (int k = 0; k < stim_q.size(); k++) begin
      send_byte(stim_q[k]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (observed() !== exp_v)
        $display("FAIL %s byte%0d (%h): got %h want %h", name, k, stim_q[k], observed(), exp_v);
      else n_pass++;
      idle_v = exp_v;
      idle_v[EW-1 -: 4] = 4'b0000;
      g = (k < gap_q.size()) ? gap_q[k] : 0;
      for (int c = 0; c < g; c++) begin
        @(negedge clk);
        n_checks++;
        if (observed() !== idle_v)
          $display("FAIL %s idle after byte%0d cyc%0d: got %h want %h", name, k, c, observed(), idle_v);
        else n_pass++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_len = '0; m_payload = '0;
    n_checks++;
    if (observed() !== '0) $display("FAIL reset outputs: got %h want 0", observed());
    else n_pass++;
    n_checks++;
    if (o_dbg.state !== ST_IDLE) $display("FAIL reset state: got %0d want %0d", o_dbg.state, ST_IDLE);
    else n_pass++;
  endtask

  task automatic test_good_frame();
    logic [8*MAX_LEN-1:0] want;
    stim_q = '{8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    gap_q = '{1, 0, 2, 0, 1, 3};
    run_stream("good");
    want = '0;
    want[23:0] = 24'h332211;
    n_checks++;
    if (o_len !== 4'd3 || o_payload !== want)
      $display("FAIL good result: got len %0d pay %h want len 3 pay %h", o_len, o_payload, want);
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    stim_q = '{8'hFE, 8'h02, 8'hAA, 8'h55, 8'h00};
    gap_q = '{};
    run_stream("bad_chk");
    n_checks++;
    if (o_len !== 4'd3 || o_payload[23:0] !== 24'h332211)
      $display("FAIL bad_chk kept: got len %0d pay %h want len 3 pay 332211", o_len, o_payload);
    else n_pass++;
  endtask

  task automatic test_len_err();
    stim_q = '{8'hFE, 8'h00, 8'hFE, 8'h09, 8'hFE, 8'h01, 8'h5A, 8'h5B};
    gap_q = '{0, 2, 0, 0, 0, 0, 0, 2};
    run_stream("len_err");
    n_checks++;
    if (o_len !== 4'd1 || o_payload !== {{(8*MAX_LEN-8){1'b0}}, 8'h5A})
      $display("FAIL len_err result: got len %0d pay %h want len 1 pay 5a", o_len, o_payload);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int first, width;
    logic busy_at;
    stim_q = '{8'hFE, 8'h02, 8'hAA};
    gap_q = '{};
    run_stream("tmo_pre");
    first = -1; width = 0; busy_at = 1'b1;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      @(negedge clk);
      if (o_err_tmo) begin
        width++;
        if (first < 0) begin
          first = k;
          busy_at = o_busy;
        end
      end
    end
    n_checks++;
    if (first != TIMEOUT) $display("FAIL tmo latency: got %0d want %0d", first, TIMEOUT);
    else n_pass++;
    n_checks++;
    if (width != 1) $display("FAIL tmo width: got %0d want 1", width);
    else n_pass++;
    n_checks++;
    if (busy_at !== 1'b0 || o_busy !== 1'b0) $display("FAIL tmo busy: got %b/%b want 0/0", busy_at, o_busy);
    else n_pass++;
    // Partial frame is discarded; the next frame parses from scratch.
    stim_q = '{8'hFE, 8'h01, 8'h77, 8'h76};
    gap_q = '{};
    run_stream("tmo_post");
  endtask

  task automatic test_tc_strobe();
    stim_q = '{8'hFE, 8'h02, 8'hAA, 8'h55, 8'hFD};
    gap_q = '{TIMEOUT - 1, TIMEOUT - 1, TIMEOUT - 1, TIMEOUT - 1, 1};
    run_stream("tc_strobe");
  endtask

  task automatic test_embedded_header();
    stim_q = '{8'h00, 8'h7F, 8'hFE, 8'h02, 8'hFE, 8'h01, 8'hFD};
    gap_q = '{};
    run_stream("embedded");
    n_checks++;
    if (o_len !== 4'd2 || o_payload[15:0] !== 16'h01FE)
      $display("FAIL embedded result: got len %0d pay %h want len 2 pay 01fe", o_len, o_payload[15:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    stim_q = '{8'hFE, 8'h03, 8'h11};
    gap_q = '{};
    run_stream("rst_pre");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_len = '0; m_payload = '0;
    n_checks++;
    if (observed() !== '0) $display("FAIL rst_mid outputs: got %h want 0", observed());
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (observed() !== '0) $display("FAIL rst_mid quiet cyc%0d: got %h want 0", c, observed());
      else n_pass++;
    end
    stim_q = '{8'hFE, 8'h02, 8'h10, 8'h20, 8'h32};
    gap_q = '{};
    run_stream("rst_post");
  endtask

  task automatic test_back_to_back();
    stim_q = '{8'hFE, 8'h01, 8'h42, 8'h43, 8'hFE, 8'h02, 8'h01, 8'h02, 8'h01,
               8'hFE, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
    gap_q = '{};
    run_stream("b2b");
  endtask

  task automatic test_random();
    int kind, len_b;
    logic [7:0] x;
    for (int s = 0; s < 20; s++) begin
      stim_q.delete();
      gap_q.delete();
      for (int j = 0; j < 6; j++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: for (int b = 0; b < $urandom_range(1, 3); b++) stim_q.push_back(8'($urandom_range(0, 8'hFD)));
          3: begin
            stim_q.push_back(HDR);
            stim_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
          end
          default: begin
            len_b = $urandom_range(1, MAX_LEN);
            stim_q.push_back(HDR);
            stim_q.push_back(8'(len_b));
            x = 8'(len_b);
            for (int b = 0; b < len_b; b++) begin
              stim_q.push_back(8'($urandom_range(0, 255)));
              x ^= stim_q[stim_q.size()-1];
            end
            if (kind == 2) x ^= 8'($urandom_range(1, 255));
            stim_q.push_back(x);
          end
        endcase
      end
      for (int k = 0; k < stim_q.size(); k++)
        gap_q.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 3));
      run_stream("random");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_tc_strobe();
    test_embedded_header();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
